nvram_x22_ctrl: RTL and testbench



---
 rtl/nvram_x22_if.sv | 39 +++
 rtl/nvram_x22_ctrl.sv | 146 ++++++++++++++
 tb/tb_nvram_x22_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_x22_if.sv
// CPU-side bus of the X2212-class NVRAM controller.
// NVRAM_HOST_PORT_EN adds the host (SD save/load) port into the shadow array.
interface nvram_x22_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 8
) ();
    logic              ce_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              store_n;
    logic              recall_n;
    logic              busy;
`ifdef NVRAM_HOST_PORT_EN
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_din;
    logic              hs_we;
    logic [DATA_W-1:0] hs_dout;

    modport master (
        output ce_n, we_n, addr, din, store_n, recall_n, hs_addr, hs_din, hs_we,
        input  dout, busy, hs_dout
    );
    modport slave (
        input  ce_n, we_n, addr, din, store_n, recall_n, hs_addr, hs_din, hs_we,
        output dout, busy, hs_dout
    );
`else
    modport master (
        output ce_n, we_n, addr, din, store_n, recall_n,
        input  dout, busy
    );
    modport slave (
        input  ce_n, we_n, addr, din, store_n, recall_n,
        output dout, busy
    );
`endif
endinterface

// File: rtl/nvram_x22_ctrl.sv
// X2212-class NVRAM: volatile working array plus shadow array with STORE/RECALL sequences.
// Optional macro NVRAM_HOST_PORT_EN exposes a host port onto the shadow array.
module nvram_x22_ctrl #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STORE_DLY   = 16,
    parameter bit          AUTO_RECALL = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    nvram_x22_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] K_LAST = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] K_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StStoreCopy, StStoreWait, StRecallCopy} state_e;

    logic [DATA_W-1:0] working [DEPTH];
    logic [DATA_W-1:0] shadow  [DEPTH];

    state_e            state_q;
    logic [ADDR_W:0]   k_q;
    logic [15:0]       wait_q;
    logic [DATA_W-1:0] pipe_q;
    logic              store_q;
    logic              recall_q;
    logic              boot_q;
    logic              busy_q;
    logic [DATA_W-1:0] dout_q;
`ifdef NVRAM_HOST_PORT_EN
    logic [DATA_W-1:0] hs_dout_q;
`endif

    logic              store_req;
    logic              recall_req;
    logic              idle;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;

    assign store_req  = store_q & ~bus.store_n;
    assign recall_req = recall_q & ~bus.recall_n;
    // The pending auto-recall cycle counts as not idle so no CPU access slips in first.
    assign idle       = (state_q == StIdle) && !boot_q;
    assign rd_idx     = k_q[ADDR_W-1:0];
    assign wr_idx     = ADDR_W'(k_q - K_ONE);

    // Arrays are not reset; contents survive reset and partial sequences.
    always_ff @(posedge clk) begin
        if (state_q == StRecallCopy && k_q != '0) begin
            working[wr_idx] <= pipe_q;
        end else if (idle && !bus.ce_n && !bus.we_n) begin
            working[bus.addr] <= bus.din;
        end
        if (state_q == StStoreCopy && k_q != '0) begin
            shadow[wr_idx] <= pipe_q;
`ifdef NVRAM_HOST_PORT_EN
        end else if (idle && bus.hs_we) begin
            shadow[bus.hs_addr] <= bus.hs_din;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            wait_q    <= '0;
            pipe_q    <= '0;
            store_q   <= 1'b1;
            recall_q  <= 1'b1;
            boot_q    <= AUTO_RECALL;
            busy_q    <= 1'b0;
            dout_q    <= '0;
`ifdef NVRAM_HOST_PORT_EN
            hs_dout_q <= '0;
`endif
        end else begin
            store_q  <= bus.store_n;
            recall_q <= bus.recall_n;
`ifdef NVRAM_HOST_PORT_EN
            if (idle) begin
                hs_dout_q <= shadow[bus.hs_addr];
            end
`endif
            unique case (state_q)
                StIdle: begin
                    k_q <= '0;
                    if (!boot_q && !bus.ce_n && bus.we_n) begin
                        dout_q <= working[bus.addr];
                    end
                    if (boot_q) begin
                        boot_q  <= 1'b0;
                        state_q <= StRecallCopy;
                        busy_q  <= 1'b1;
                    end else if (store_req) begin
                        // Store wins a simultaneous request; the recall is dropped.
                        state_q <= StStoreCopy;
                        busy_q  <= 1'b1;
                    end else if (recall_req) begin
                        state_q <= StRecallCopy;
                        busy_q  <= 1'b1;
                    end
                end
                StStoreCopy: begin
                    pipe_q <= working[rd_idx];
                    if (k_q == K_LAST) begin
                        state_q <= StStoreWait;
                        wait_q  <= 16'(STORE_DLY - 1);
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + K_ONE;
                    end
                end
                StStoreWait: begin
                    if (wait_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        wait_q <= wait_q - 16'd1;
                    end
                end
                StRecallCopy: begin
                    pipe_q <= shadow[rd_idx];
                    if (k_q == K_LAST) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + K_ONE;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout    = dout_q;
    assign bus.busy    = busy_q;
`ifdef NVRAM_HOST_PORT_EN
    assign bus.hs_dout = hs_dout_q;
`endif
endmodule

// File: tb/tb_nvram_x22_ctrl.sv
// Directed bench for nvram_x22_ctrl (DEPTH=256, STORE_DLY=16, AUTO_RECALL=1).
// Host-port checks are built when NVRAM_HOST_PORT_EN is defined.
module tb_nvram_x22_ctrl;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;
    logic [DATA_W-1:0] d;

    always #5 clk = ~clk;

    nvram_x22_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    nvram_x22_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STORE_DLY  (16),
        .AUTO_RECALL(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        bus.ce_n = 1'b0;
        bus.we_n = 1'b0;
        bus.addr = a;
        bus.din  = v;
        tick();
        bus.ce_n = 1'b1;
        bus.we_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] v);
        bus.ce_n = 1'b0;
        bus.we_n = 1'b1;
        bus.addr = a;
        tick();
        v = bus.dout;
        bus.ce_n = 1'b1;
    endtask

    // Counts busy cycles (bounded); kind 1 = CPU write 0x10<=F, 2 = store pulse, 3 = host write.
    task automatic run_busy(input int poke_at, input int kind, output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            if (cnt == poke_at) begin
                case (kind)
                    1: begin
                        bus.ce_n = 1'b0;
                        bus.we_n = 1'b0;
                        bus.addr = 8'h10;
                        bus.din  = 4'hF;
                    end
                    2: bus.store_n = 1'b0;
`ifdef NVRAM_HOST_PORT_EN
                    3: begin
                        bus.hs_we   = 1'b1;
                        bus.hs_addr = 8'h21;
                        bus.hs_din  = 4'h5;
                    end
`endif
                    default: ;
                endcase
            end else begin
                bus.ce_n    = 1'b1;
                bus.we_n    = 1'b1;
                bus.store_n = 1'b1;
`ifdef NVRAM_HOST_PORT_EN
                bus.hs_we   = 1'b0;
`endif
            end
            tick();
            cnt++;
        end
        bus.ce_n    = 1'b1;
        bus.we_n    = 1'b1;
        bus.store_n = 1'b1;
`ifdef NVRAM_HOST_PORT_EN
        bus.hs_we   = 1'b0;
`endif
    endtask

    initial begin
        bus.ce_n     = 1'b1;
        bus.we_n     = 1'b1;
        bus.addr     = '0;
        bus.din      = '0;
        bus.store_n  = 1'b1;
        bus.recall_n = 1'b1;
`ifdef NVRAM_HOST_PORT_EN
        bus.hs_addr  = '0;
        bus.hs_din   = '0;
        bus.hs_we    = 1'b0;
`endif
        repeat (3) tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dout", bus.dout, 4'h0);
`ifdef NVRAM_HOST_PORT_EN
        check("rst_hs_dout", bus.hs_dout, 4'h0);
`endif

        // Auto recall on reset release
        rst_n = 1'b1;
        tick();
        check("boot_busy", bus.busy, 1'b1);
        run_busy(-1, 0, n);
        check("boot_len", n, 257);

        cpu_write(8'h05, 4'hA);
        cpu_write(8'h10, 4'h3);
        cpu_write(8'd50, 4'h1);
        cpu_write(8'd150, 4'h1);
        cpu_read(8'h05, d);
        check("rd5", d, 4'hA);
        bus.addr = 8'h10;
        tick();
        check("dout_hold", bus.dout, 4'hA);

        // Store with a blocked CPU write in the middle
        bus.store_n = 1'b0;
        tick();
        bus.store_n = 1'b1;
        check("st_busy", bus.busy, 1'b1);
        run_busy(50, 1, n);
        check("st_len", n, 273);
        cpu_read(8'h10, d);
        check("wr_blocked", d, 4'h3);

        // Corrupt working, recall restores from shadow
        cpu_write(8'h10, 4'h5);
        cpu_write(8'h05, 4'h0);
        bus.recall_n = 1'b0;
        tick();
        bus.recall_n = 1'b1;
        run_busy(-1, 0, n);
        check("rc_len", n, 257);
        cpu_read(8'h10, d);
        check("shadow10", d, 4'h3);
        cpu_read(8'h05, d);
        check("shadow5", d, 4'hA);

        // Simultaneous requests: store wins, recall dropped
        bus.store_n  = 1'b0;
        bus.recall_n = 1'b0;
        tick();
        bus.store_n  = 1'b1;
        bus.recall_n = 1'b1;
        run_busy(-1, 0, n);
        check("both_len", n, 273);
        repeat (5) tick();
        check("no_recall", bus.busy, 1'b0);

        // Store edge during recall is not queued
        bus.recall_n = 1'b0;
        tick();
        bus.recall_n = 1'b1;
        run_busy(10, 2, n);
        check("rc_poke_len", n, 257);
        repeat (5) tick();
        check("no_queued_store", bus.busy, 1'b0);

        // Reset at k=100 of a store
        cpu_write(8'd50, 4'h7);
        cpu_write(8'd150, 4'h9);
        bus.store_n = 1'b0;
        tick();
        bus.store_n = 1'b1;
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", bus.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("reboot_busy", bus.busy, 1'b1);
        run_busy(-1, 0, n);
        check("reboot_len", n, 257);
        cpu_read(8'd50, d);
        check("partial_50", d, 4'h7);
        cpu_read(8'd150, d);
        check("partial_150", d, 4'h1);

`ifdef NVRAM_HOST_PORT_EN
        bus.hs_we   = 1'b1;
        bus.hs_addr = 8'h20;
        bus.hs_din  = 4'h7;
        tick();
        bus.hs_addr = 8'h21;
        bus.hs_din  = 4'h2;
        tick();
        bus.hs_we   = 1'b0;
        bus.hs_addr = 8'h20;
        tick();
        check("hs_rd20", bus.hs_dout, 4'h7);
        bus.recall_n = 1'b0;
        tick();
        bus.recall_n = 1'b1;
        run_busy(10, 3, n);
        check("hs_rc_len", n, 257);
        cpu_read(8'h20, d);
        check("hs_recall20", d, 4'h7);
        cpu_read(8'h21, d);
        check("hs_recall21", d, 4'h2);
        bus.hs_addr = 8'h21;
        tick();
        check("hs_busy_wr", bus.hs_dout, 4'h2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
